// File: rtl/bpu_btb_pkg.sv
// Shared branch-prediction types: physical address, EX0 train packet,
// BTB entry layout, table defaults and the 2-bit saturating counter update.
package bpu_btb_pkg;

   localparam int PADDR_BITS        = 64;
   localparam int BTB_ENTRIES_DFLT  = 64;
   localparam int BTB_TAG_BITS_DFLT = 12;

   typedef logic [PADDR_BITS-1:0] t_paddr;

   typedef struct packed {
      logic   valid;
      logic   taken;
      t_paddr pc;
      t_paddr target;
   } t_bpu_train_pkt;

   typedef struct packed {
      logic                         valid;
      logic [BTB_TAG_BITS_DFLT-1:0] tag;
      t_paddr                       target;
      logic [1:0]                   ctr;
   } t_btb_entry;

   // Saturating 2-bit direction counter: 0..3, taken moves up, not-taken down.
   function automatic logic [1:0] f_sat2_upd(input logic [1:0] ctr, input logic tkn);
      logic [1:0] w_nxt;
      if (tkn) begin
         w_nxt = (ctr == 2'd3) ? 2'd3 : (ctr + 2'd1);
      end else begin
         w_nxt = (ctr == 2'd0) ? 2'd0 : (ctr - 2'd1);
      end
      return w_nxt;
   endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer. Fetch lookups are answered one cycle
// later from registered outputs; EX0 training is registered once (trn_q) and
// then read-modify-writes the flop-based table the following cycle.
module bpu_btb
   import bpu_btb_pkg::*;
#(
   parameter int ENTRIES  = BTB_ENTRIES_DFLT,
   parameter int TAG_BITS = BTB_TAG_BITS_DFLT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush_tbl,
   input  logic           pred_req_if0,
   input  t_paddr         pred_pc_if0,
   output logic           pred_vld_if1,
   output logic           pred_tkn_if1,
   output t_paddr         pred_tgt_if1,
   input  t_bpu_train_pkt train_pkt_ex0
);

   localparam int IDX     = $clog2(ENTRIES);
   localparam int TAG_LSB = IDX + 2;
   localparam int TAG_MSB = TAG_LSB + TAG_BITS - 1;

   // Table storage: valid bits are reset, payload fields are don't-care until allocated
   logic [ENTRIES-1:0]  r_valid;
   logic [TAG_BITS-1:0] r_tag [ENTRIES];
   t_paddr              r_tgt [ENTRIES];
   logic [1:0]          r_ctr [ENTRIES];

   // Train register (trn_q): only the fields the T1 update actually consumes
   logic                r_trn_vld;
   logic                r_trn_tkn;
   logic [IDX-1:0]      r_trn_idx;
   logic [TAG_BITS-1:0] r_trn_tag;
   t_paddr              r_trn_tgt;

   // Lookup path
   logic [IDX-1:0]      w_lk_idx;
   logic [TAG_BITS-1:0] w_lk_tag;
   logic                w_lk_hit;
   logic                w_lk_tkn;
   t_paddr              w_lk_tgt;

   // T1 update path
   logic                w_t1_hit;
   logic                w_t1_alloc;

   // Train pc bits outside index/tag never influence the table
   logic                w_unused;

   assign w_unused = ^{train_pkt_ex0.pc[PADDR_BITS-1:TAG_MSB+1], train_pkt_ex0.pc[1:0]};

   assign w_lk_idx = pred_pc_if0[IDX+1:2];
   assign w_lk_tag = pred_pc_if0[TAG_MSB:TAG_LSB];
   assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign w_lk_tkn = w_lk_hit && r_ctr[w_lk_idx][1];
   assign w_lk_tgt = w_lk_tkn ? r_tgt[w_lk_idx] : (pred_pc_if0 + 64'd4);

   assign w_t1_hit   = r_trn_vld && r_valid[r_trn_idx] && (r_tag[r_trn_idx] == r_trn_tag);
   assign w_t1_alloc = r_trn_vld && !w_t1_hit && r_trn_tkn;

   // T0: capture a valid training packet; an idle cycle only drops the valid bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_trn_vld <= 1'b0;
         r_trn_tkn <= 1'b0;
         r_trn_idx <= '0;
         r_trn_tag <= '0;
         r_trn_tgt <= '0;
      end else if (train_pkt_ex0.valid) begin
         r_trn_vld <= 1'b1;
         r_trn_tkn <= train_pkt_ex0.taken;
         r_trn_idx <= train_pkt_ex0.pc[IDX+1:2];
         r_trn_tag <= train_pkt_ex0.pc[TAG_MSB:TAG_LSB];
         r_trn_tgt <= train_pkt_ex0.target;
      end else begin
         r_trn_vld <= 1'b0;
      end
   end

   // Valid bits: flush wins over a same-cycle allocate
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
      end else if (flush_tbl) begin
         r_valid <= '0;
      end else if (w_t1_alloc) begin
         r_valid[r_trn_idx] <= 1'b1;
      end else begin
         r_valid <= r_valid;
      end
   end

   // T1 payload update: counter/target on hit, full overwrite on taken miss
   always_ff @(posedge clk) begin
      if (w_t1_hit) begin
         r_ctr[r_trn_idx] <= f_sat2_upd(r_ctr[r_trn_idx], r_trn_tkn);
         if (r_trn_tkn) begin
            r_tgt[r_trn_idx] <= r_trn_tgt;
         end
      end else if (w_t1_alloc) begin
         r_tag[r_trn_idx] <= r_trn_tag;
         r_tgt[r_trn_idx] <= r_trn_tgt;
         r_ctr[r_trn_idx] <= 2'd2;
      end
   end

   // IF1 prediction outputs: zero whenever no request was made the cycle before
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pred_vld_if1 <= 1'b0;
         pred_tkn_if1 <= 1'b0;
         pred_tgt_if1 <= '0;
      end else if (pred_req_if0) begin
         pred_vld_if1 <= 1'b1;
         pred_tkn_if1 <= w_lk_tkn;
         pred_tgt_if1 <= w_lk_tgt;
      end else begin
         pred_vld_if1 <= 1'b0;
         pred_tkn_if1 <= 1'b0;
         pred_tgt_if1 <= '0;
      end
   end

endmodule

// File: tb/tb_bpu_btb.sv
// Directed bench for bpu_btb: reset, allocate/train latency, counter
// saturation, aliasing, lookup/write conflict, flush interaction, async reset.
module tb_bpu_btb;
   import bpu_btb_pkg::*;

   logic           clk;
   logic           reset;
   logic           flush_tbl;
   logic           pred_req_if0;
   t_paddr         pred_pc_if0;
   logic           pred_vld_if1;
   logic           pred_tkn_if1;
   t_paddr         pred_tgt_if1;
   t_bpu_train_pkt train_pkt_ex0;

   int total;
   int bad;

   bpu_btb #(.ENTRIES(64), .TAG_BITS(12)) dut (
      .clk           (clk),
      .reset         (reset),
      .flush_tbl     (flush_tbl),
      .pred_req_if0  (pred_req_if0),
      .pred_pc_if0   (pred_pc_if0),
      .pred_vld_if1  (pred_vld_if1),
      .pred_tkn_if1  (pred_tkn_if1),
      .pred_tgt_if1  (pred_tgt_if1),
      .train_pkt_ex0 (train_pkt_ex0)
   );

   // Free-running core clock, period 10
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge
   task automatic step(input logic req, input logic [63:0] pc,
                       input logic tv, input logic tt,
                       input logic [63:0] tpc, input logic [63:0] ttgt,
                       input logic fl);
      pred_req_if0  = req;
      pred_pc_if0   = pc;
      train_pkt_ex0 = '{valid: tv, taken: tt, pc: tpc, target: ttgt};
      flush_tbl     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic lk(input logic [63:0] pc);
      step(1'b1, pc, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
   endtask

   task automatic trn(input logic [63:0] pc, input logic tkn, input logic [63:0] tgt);
      step(1'b0, 64'h0, 1'b1, tkn, pc, tgt, 1'b0);
   endtask

   task automatic chk(input string tag, input logic evld, input logic etkn, input logic [63:0] etgt);
      total++;
      assert ({pred_vld_if1, pred_tkn_if1, pred_tgt_if1} === {evld, etkn, etgt}) else begin
         bad++;
         $error("FAIL %s: observed vld=%0b tkn=%0b tgt=%h expected vld=%0b tkn=%0b tgt=%h",
                tag, pred_vld_if1, pred_tkn_if1, pred_tgt_if1, evld, etkn, etgt);
      end
   endtask

   initial begin
      clk           = 1'b0;
      reset         = 1'b0;
      total         = 0;
      bad           = 0;
      flush_tbl     = 1'b0;
      pred_req_if0  = 1'b0;
      pred_pc_if0   = 64'h0;
      train_pkt_ex0 = '0;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 1'b0, 1'b0, 64'h0);
      reset = 1'b1;

      idle();
      chk("no_request", 1'b0, 1'b0, 64'h0);
      lk(64'h1000);
      chk("empty_lookup", 1'b1, 1'b0, 64'h1004);

      // Allocate: train, next-cycle lookup misses, the one after hits (ctr=2)
      step(1'b1, 64'h1000, 1'b1, 1'b1, 64'h1000, 64'h2000, 1'b0);
      chk("alloc_train_cycle", 1'b1, 1'b0, 64'h1004);
      lk(64'h1000);
      chk("alloc_t1_cycle", 1'b1, 1'b0, 64'h1004);
      lk(64'h1000);
      chk("alloc_visible", 1'b1, 1'b1, 64'h2000);

      // Three back-to-back taken trains: 2 -> 3 -> 3 -> 3
      trn(64'h1000, 1'b1, 64'h2000);
      trn(64'h1000, 1'b1, 64'h2000);
      trn(64'h1000, 1'b1, 64'h2000);
      idle();
      lk(64'h1000);
      chk("sat_up", 1'b1, 1'b1, 64'h2000);

      // Hysteresis: 3 -> 2 still taken, target kept on not-taken
      trn(64'h1000, 1'b0, 64'hdead0);
      idle();
      lk(64'h1000);
      chk("nt_ctr2", 1'b1, 1'b1, 64'h2000);
      trn(64'h1000, 1'b0, 64'h0);
      idle();
      lk(64'h1000);
      chk("nt_ctr1", 1'b1, 1'b0, 64'h1004);

      // Down saturation: 1 -> 0 -> 0, then one taken -> 1 (still not taken)
      trn(64'h1000, 1'b0, 64'h0);
      trn(64'h1000, 1'b0, 64'h0);
      idle();
      lk(64'h1000);
      chk("sat_down", 1'b1, 1'b0, 64'h1004);
      trn(64'h1000, 1'b1, 64'h2000);
      idle();
      lk(64'h1000);
      chk("ctr0_to_1", 1'b1, 1'b0, 64'h1004);
      trn(64'h1000, 1'b1, 64'h2400);
      idle();
      lk(64'h1000);
      chk("ctr2_new_target", 1'b1, 1'b1, 64'h2400);

      // Alias: 0x1100 shares index 0 with a different tag
      lk(64'h1100);
      chk("alias_miss", 1'b1, 1'b0, 64'h1104);
      trn(64'h1100, 1'b1, 64'h5000);
      idle();
      lk(64'h1100);
      chk("alias_alloc", 1'b1, 1'b1, 64'h5000);
      lk(64'h1000);
      chk("alias_evicted", 1'b1, 1'b0, 64'h1004);

      // Same-cycle lookup and T1 write: lookup sees the old entry
      trn(64'h1000, 1'b1, 64'h6000);
      lk(64'h1000);
      chk("conflict_old", 1'b1, 1'b0, 64'h1004);
      lk(64'h1000);
      chk("conflict_new", 1'b1, 1'b1, 64'h6000);

      // Flush in the T1 cycle of an allocate: flush wins, flush-cycle lookup is pre-flush
      trn(64'h3000, 1'b1, 64'h7000);
      step(1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
      chk("flush_cycle_lookup", 1'b1, 1'b1, 64'h6000);
      lk(64'h3000);
      chk("flush_beats_alloc", 1'b1, 1'b0, 64'h3004);
      lk(64'h1000);
      chk("flush_cleared", 1'b1, 1'b0, 64'h1004);

      // Flush in the T0 cycle does not drop trn_q: allocate lands afterwards
      step(1'b0, 64'h0, 1'b1, 1'b1, 64'h3000, 64'h7000, 1'b1);
      idle();
      lk(64'h3000);
      chk("trnq_survives_flush", 1'b1, 1'b1, 64'h7000);

      // Asynchronous reset with a train pending in trn_q
      step(1'b1, 64'h3000, 1'b1, 1'b1, 64'h4000, 64'h8000, 1'b0);
      chk("pre_reset_lookup", 1'b1, 1'b1, 64'h7000);
      train_pkt_ex0 = '0;
      pred_req_if0  = 1'b0;
      reset         = 1'b0;
      #1;
      chk("async_reset_outputs", 1'b0, 1'b0, 64'h0);
      #2;
      reset = 1'b1;
      idle();
      lk(64'h4000);
      chk("reset_drops_trnq", 1'b1, 1'b0, 64'h4004);
      lk(64'h3000);
      chk("reset_clears_table", 1'b1, 1'b0, 64'h3004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bpu_btb.md
# bpu_btb

Direct-mapped branch target buffer with 2-bit saturating direction counters. Consumes the EX0 branch-resolution training stream (`t_bpu_train_pkt`) from the integer branch unit and answers one-per-cycle fetch lookups with a registered taken/target prediction. Sits between EX (trainer) and IF (consumer), with no stall path in either direction.

## Interface
Parameters:
- `ENTRIES`, 64: table depth; power of two, ≥ 4.
- `TAG_BITS`, 12: stored tag width.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `flush_tbl`  in  1  synchronous clear of all entry valid bits.
- `pred_req_if0`  in  1  fetch lookup request.
- `pred_pc_if0`  in  t_paddr  lookup PC; 4-byte aligned.
- `pred_vld_if1`  out  1  prediction valid, registered.
- `pred_tkn_if1`  out  1  predicted taken.
- `pred_tgt_if1`  out  t_paddr  predicted next PC.
- `train_pkt_ex0`  in  t_bpu_train_pkt  contains `valid`, `taken`, `pc`, and `target`.

## Operation
- Index `IDX = log2(ENTRIES)`.
  - index = `pc[IDX+1:2]`.
  - tag = `pc[IDX+2+TAG_BITS-1:IDX+2]`.
  - Bits `pc[1:0]` are ignored.
- Entry fields are `valid`, `tag[TAG_BITS]`, `target` (t_paddr), and `ctr[2]`.
- Lookup (IF0):
  - hit = `valid && tag match`.
  - taken = `hit && ctr[1]`.
  - Target = entry target when taken; otherwise `pc+4`, with 64-bit wrap and no carry out.
- Training is two-stage:
  - **T0:** `train_pkt_ex0` with `valid=1` is registered into a one-entry train register (`trn_q`).
  - **T1:** the table is read-modify-written from `trn_q`.
- T1 update rules:
  - **Hit, taken:** `ctr` saturating-increment (max 3); `target` ← pkt.target.
  - **Hit, not-taken:** `ctr` saturating-decrement (min 0); `target` unchanged.
  - **Miss, taken:** allocate and overwrite any resident entry: `valid=1`, tag, target, `ctr=2` (weakly taken).
  - **Miss, not-taken:** no change.
- Back-to-back trains to the same index:
  - Each train's T1 sees the previous T1's write, because the table is in flops written at end of cycle.
  - N consecutive taken trains therefore move `ctr` by N, saturating.
- Same-cycle lookup and T1 write to the same index: the lookup sees the pre-write entry. There is no bypass.
- `flush_tbl`:
  - Clears all valid bits at end of cycle.
  - If a T1 write occurs in the same cycle, flush wins: the entry ends invalid.
  - `trn_q` is not cleared by flush.
  - A lookup in the flush cycle uses pre-flush state.
- Reset (`reset==0`), asynchronous:
  - All valid bits = 0, `trn_q.valid` = 0, all outputs = 0.
  - `ctr`, `tag`, and `target` are don't-care.
  - Deassertion is synchronized externally.
  - Reset mid-training drops `trn_q`.

## Timing
- Prediction latency is 1 cycle: a request in cycle N gives `pred_*_if1` in cycle N+1.
- `pred_vld_if1=0` in any cycle following no request.
- `pred_tkn_if1` and `pred_tgt_if1` are 0 whenever `pred_vld_if1=0`.
- Train latency:
  - Packet presented in cycle N is registered at end of N.
  - Table write at end of N+1.
  - First visible to a lookup issued in cycle N+2.
- Throughput is one lookup plus one train per cycle, with no backpressure.
- Reset values: `pred_vld_if1=0`, `pred_tkn_if1=0`, `pred_tgt_if1=0`.

## Structure
- Add to `common.pkg`:
  - `t_btb_entry` typedef.
  - `BTB_ENTRIES_DFLT` and `BTB_TAG_BITS_DFLT` constants.
  - `f_sat2_upd(ctr, tkn)` function.
- `t_bpu_train_pkt` already lives in `common.pkg` and is reused unchanged.
- No sub-module; table, train register and output flops stay in one module.
- SIMULATION-only `UINFO` per train shows index, hit, old/new ctr, and target.

## Test plan
- **Reset/empty:** hold `reset=0` 3 cycles, release, then look up 0x1000 → `pred_vld_if1=1`, `tkn=0`, `tgt=0x1004`.
- **Allocate then train:**
  - Train `{pc=0x1000, taken=1, target=0x2000}` in cycle 5.
  - Lookup 0x1000 in cycle 6 → `tkn=0`, `tgt=0x1004`.
  - Lookup 0x1000 in cycle 7 → `tkn=1`, `tgt=0x2000`.
- **Counter saturation and hysteresis:**
  - Three taken trains on 0x1000 → ctr=3.
  - One not-taken → ctr=2; lookup still `tkn=1`.
  - Second not-taken → ctr=1; lookup `tkn=0`, `tgt=0x1004`.
- **Alias/tag miss:**
  - With ENTRIES=64, 0x1000 is allocated.
  - Lookup 0x1000+(64·4·1)=0x1100 (same index, different tag) → `tkn=0`, `tgt=0x1104`.
  - Taken train on 0x1100 replaces the entry; lookup 0x1000 then misses.
- **Same-cycle conflict:** T1 write to index of 0x1000 in the same cycle as a lookup of 0x1000 → that lookup returns old state; the lookup next cycle returns new state.
- **Flush vs train:** assert `flush_tbl` in the same cycle as a T1 allocate on 0x3000 → lookup 0x3000 two cycles later gives `tkn=0`, `tgt=0x3004`.
